// File: rtl/muldiv_sched_pkg.sv
// rtl/muldiv_sched_pkg.sv - M-extension op encodings and operand signedness helpers.
package muldiv_sched_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mul_ops_t;

  function automatic logic is_div_op(input mul_ops_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic a_signed(input mul_ops_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input mul_ops_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sched_rr_arbiter.sv
// rtl/muldiv_sched_rr_arbiter.sv - round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     id,
  output logic               any
);

  int idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - shares one iterative multiplier and one divider among NUM_REQ requesters,
// with sign pre/post-processing, divide-by-zero short-circuit and a one-entry divide cache.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*3-1:0]  req_op,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [31:0]           resp_data,
  input  logic                  resp_ready,
  input  logic                  flush,
  output logic                  m_start,
  input  logic                  m_ready,
  input  logic                  m_done,
  input  logic [63:0]           m_product,
  output logic [31:0]           m_a,
  output logic [31:0]           m_b,
  output logic                  d_start,
  input  logic                  d_ready,
  input  logic                  d_done,
  input  logic [31:0]           d_quotient,
  input  logic [31:0]           d_remainder,
  output logic [31:0]           d_a,
  output logic [31:0]           d_b
);

  typedef logic [2:0] sched_state_t;
  localparam sched_state_t IDLE  = 3'd0;
  localparam sched_state_t MWAIT = 3'd1;
  localparam sched_state_t DWAIT = 3'd2;
  localparam sched_state_t RESP  = 3'd3;
  localparam sched_state_t DRAIN = 3'd4;

  sched_state_t       state;
  logic [IDW-1:0]     rr_ptr, gnt_id, next_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any, grant_ok;
  logic [2:0]         op_bits;
  mul_ops_t           op_sel, op_q;
  logic [31:0]        a_sel, b_sel, a_q, b_q, mag_a, mag_b;
  logic               neg_a_sel, neg_b_sel, neg_a, neg_b, issued;
  logic               cache_valid, cache_signed, cache_hit;
  logic [31:0]        cache_a, cache_b, cache_quo, cache_rem;
  logic [63:0]        prod_fix;
  logic [31:0]        mul_res, quo_fix, rem_fix, div_res;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .id    (gnt_id),
    .any   (gnt_any)
  );

  assign op_bits   = req_op[int'(gnt_id)*3 +: 3];
  assign op_sel    = mul_ops_t'(op_bits);
  assign a_sel     = req_a[int'(gnt_id)*32 +: 32];
  assign b_sel     = req_b[int'(gnt_id)*32 +: 32];
  assign neg_a_sel = a_signed(op_sel) & a_sel[31];
  assign neg_b_sel = b_signed(op_sel) & b_sel[31];
  assign cache_hit = cache_valid && (cache_a == a_sel) && (cache_b == b_sel) &&
                     (cache_signed == a_signed(op_sel));

  // Gated by rst so no accept pulse leaks out while reset is held with requests pending.
  assign grant_ok  = (state == IDLE) && !flush && !rst && gnt_any;
  assign req_ready = grant_ok ? gnt : '0;

  assign m_start    = (state == MWAIT) && !flush && (issued || m_ready);
  assign d_start    = (state == DWAIT) && !flush && (issued || d_ready);
  assign m_a        = mag_a;
  assign m_b        = mag_b;
  assign d_a        = mag_a;
  assign d_b        = mag_b;
  assign resp_valid = (state == RESP);

  assign prod_fix = (neg_a ^ neg_b) ? (64'd0 - m_product) : m_product;
  assign mul_res  = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  assign quo_fix  = (neg_a ^ neg_b) ? (32'd0 - d_quotient) : d_quotient;
  assign rem_fix  = neg_a ? (32'd0 - d_remainder) : d_remainder;
  assign div_res  = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quo_fix;
  assign next_ptr = (resp_id == IDW'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      resp_id      <= '0;
      resp_data    <= '0;
      op_q         <= OP_MUL;
      a_q          <= '0;
      b_q          <= '0;
      mag_a        <= '0;
      mag_b        <= '0;
      neg_a        <= 1'b0;
      neg_b        <= 1'b0;
      issued       <= 1'b0;
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_quo    <= '0;
      cache_rem    <= '0;
    end else begin
      if (flush) cache_valid <= 1'b0;
      case (state)
        IDLE: if (grant_ok) begin
          resp_id <= gnt_id;
          op_q    <= op_sel;
          a_q     <= a_sel;
          b_q     <= b_sel;
          neg_a   <= neg_a_sel;
          neg_b   <= neg_b_sel;
          mag_a   <= neg_a_sel ? (32'd0 - a_sel) : a_sel;
          mag_b   <= neg_b_sel ? (32'd0 - b_sel) : b_sel;
          issued  <= 1'b0;
          if (!is_div_op(op_sel)) begin
            state <= MWAIT;
          end else if (b_sel == 32'd0) begin
            resp_data <= ((op_sel == OP_REM) || (op_sel == OP_REMU)) ? a_sel : 32'hFFFF_FFFF;
            state     <= RESP;
          end else if (cache_hit) begin
            resp_data <= ((op_sel == OP_REM) || (op_sel == OP_REMU)) ? cache_rem : cache_quo;
            state     <= RESP;
          end else begin
            state <= DWAIT;
          end
        end
        MWAIT: begin
          if (flush) begin
            // A done arriving with the flush means the core is already idle: no drain needed.
            state <= (issued && !m_done) ? DRAIN : IDLE;
          end else begin
            if (m_start) issued <= 1'b1;
            if (issued && m_done) begin
              resp_data <= mul_res;
              state     <= RESP;
            end
          end
        end
        DWAIT: begin
          if (flush) begin
            state <= (issued && !d_done) ? DRAIN : IDLE;
          end else begin
            if (d_start) issued <= 1'b1;
            if (issued && d_done) begin
              resp_data    <= div_res;
              cache_valid  <= 1'b1;
              cache_signed <= a_signed(op_q);
              cache_a      <= a_q;
              cache_b      <= b_q;
              cache_quo    <= quo_fix;
              cache_rem    <= rem_fix;
              state        <= RESP;
            end
          end
        end
        RESP: begin
          if (flush) begin
            state <= IDLE;
          end else if (resp_ready) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        DRAIN: if (is_div_op(op_q) ? d_done : m_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Shared M-extension scheduler: arbitrates NUM_REQ requesters (e.g. EX-stage ALU, address/debug unit) onto one iterative multiplier core and one iterative divider core.
- Performs sign conversion before a core starts and sign fix-up after it finishes; returns one 32-bit result per accepted request.
- Short-circuits divide-by-zero without starting the divider.
- Keeps a one-entry divider result cache, so a DIV followed by a REM on the same operands completes without re-dividing.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IDW, $clog2(NUM_REQ) (minimum 1), width of requester id.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_op  in  NUM_REQ*3  mul_ops per requester
- req_a  in  NUM_REQ*32  operand rs1 per requester
- req_b  in  NUM_REQ*32  operand rs2 per requester
- req_ready  out  NUM_REQ  one-hot accept pulse
- resp_valid  out  1  result valid
- resp_id  out  IDW  id of the requester being answered
- resp_data  out  32  result
- resp_ready  in  1  consumer accepts response
- flush  in  1  abort in-flight op, no response
- m_start, m_ready, m_done, m_product[63:0], m_a[31:0], m_b[31:0]: multiplier core interface
- d_start, d_ready, d_done, d_quotient[31:0], d_remainder[31:0], d_a[31:0], d_b[31:0]: divider core interface

Behaviour:
- Reset (async, rst=1):
  - State IDLE; round-robin pointer 0; cache invalid.
  - req_ready, resp_valid, m_start and d_start are 0; resp_id and resp_data are 0.
- States: IDLE, MWAIT, DWAIT, RESP, DRAIN.
- IDLE:
  - Grants the first valid requester at or after the rr pointer (wrapping).
  - Pulses req_ready[i] for exactly that cycle.
  - Latches op, a, b and id.
  - Computes neg_a, neg_b and magnitudes: two's-complement negate only for signed operands.
    - MULH: both operands signed.
    - MULHSU: a signed only.
    - DIV/REM: both signed.
- Routing from IDLE:
  - Mul-class op -> MWAIT.
  - Div-class with b==0 -> RESP next cycle: quotient 0xFFFFFFFF, remainder = a.
  - Div-class cache hit -> RESP next cycle using cached quotient/remainder.
    - Hit means: cache valid, same a, same b, same signedness.
  - Any other div-class op -> DWAIT.
- MWAIT/DWAIT:
  - start is held high with stable magnitudes from the first cycle core ready is 1 until done is sampled.
  - On done: the result is fixed up and registered into resp_data; state -> RESP.
  - MUL takes product[31:0]; MULHU takes product[63:32].
  - MULH/MULHSU negate the 64-bit product when the signs differ, then take [63:32].
  - DIV negates the quotient if neg_a^neg_b; REM negates the remainder if neg_a.
  - Divider completion writes the cache (a, b, signedness, signed quotient, signed remainder) and sets it valid.
- RESP:
  - resp_valid is held with stable resp_id/resp_data until resp_ready.
  - On resp_ready: rr pointer = granted id + 1 (mod NUM_REQ); state -> IDLE.
  - No new grant in the handshake cycle.
- Latency from the accept cycle N:
  - Short-circuit or cache hit: resp_valid at N+1.
  - Core path: resp_valid the cycle after done.
- flush:
  - In IDLE: suppresses the grant.
  - In RESP: drops the response; -> IDLE.
  - In MWAIT/DWAIT with start already issued: deassert start, -> DRAIN.
  - In MWAIT/DWAIT before the core accepted: -> IDLE.
  - DRAIN waits for core done, discards the result, leaves the cache unchanged, then -> IDLE.
  - flush always invalidates the cache.
- Simultaneous events:
  - flush wins over resp_ready and over done.
  - Multiple valid requesters: only one is granted per IDLE cycle.
  - A requester must hold valid/op/operands until its req_ready pulse.
- Boundaries:
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 via the normal path.
  - rr pointer wraps at NUM_REQ-1 -> 0.

Decomposition:
- types package: mul_ops enum (mul=0, mulh, mulhsu, mulhu, div, divu, rem, remu = RISC-V funct3), plus helper functions is_div_op, a_signed, b_signed.
- sched_state_t enum local to the module.
- One sub-module, rr_arbiter: NUM_REQ-wide request vector plus pointer -> one-hot grant and encoded id.

Test Plan:
- Req0 MUL a=7, b=-3 -> resp_data 0xFFFFFFEB, resp_id 0; m_start held until m_done.
- Req0 MULH a=0x80000000, b=0x80000000 -> 0x40000000. Req0 MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- Req1 DIV a=-7, b=2 -> 0xFFFFFFFD. Then REM with the same operands -> 0xFFFFFFFF at N+1, with d_start never asserted.
- DIVU a=5, b=0 -> 0xFFFFFFFF at N+1; REMU a=5, b=0 -> 5; no d_start. DIV 0x80000000 / -1 -> 0x80000000.
- Both requesters valid continuously, each with MUL 2*3 -> grants alternate 0,1,0,1; every resp_data is 6. resp_ready held low 5 cycles -> response stable throughout.
- flush mid-DWAIT -> DRAIN until d_done, no resp_valid, cache invalid. Async rst mid-MWAIT -> all outputs 0 immediately.
